// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_ctrl_pkg;

    // MDU class of the instruction sitting in ID
    typedef enum logic [1:0] {
        MDU_NONE = 2'b00,
        MDU_MUL  = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_MFHL = 2'b11
    } mdu_op_e;

    // MDU sequencer state
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // $zero is hardwired, so a load into it never creates a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
interface hazard_stall_ctrl_if;
    logic [4:0] iIdRegRs;
    logic [4:0] iIdRegRt;
    logic       iIdUsesRt;
    logic [1:0] iIdMduOp;
    logic       iExMemRead;
    logic [4:0] iExRegRt;
    logic       iExBranchTaken;
    logic       oPcWrite;
    logic       oIfIdWrite;
    logic       oIfIdFlush;
    logic       oIdExBubble;
    logic       oMduStart;
    logic       oMduIsDiv;
    logic       oMduBusy;

    // Pipeline side: presents ID/EX information, consumes the controls
    modport master (
        output iIdRegRs, iIdRegRt, iIdUsesRt, iIdMduOp,
               iExMemRead, iExRegRt, iExBranchTaken,
        input  oPcWrite, oIfIdWrite, oIfIdFlush, oIdExBubble,
               oMduStart, oMduIsDiv, oMduBusy
    );

    // Controller side
    modport slave (
        input  iIdRegRs, iIdRegRt, iIdUsesRt, iIdMduOp,
               iExMemRead, iExRegRt, iExBranchTaken,
        output oPcWrite, oIfIdWrite, oIfIdFlush, oIdExBubble,
               oMduStart, oMduIsDiv, oMduBusy
    );
endinterface

// File: rtl/hazard_stall_ctrl_mdu_sequencer.sv
// Multiply/divide unit sequencer: issues one start pulse and holds busy
// for exactly MUL_CYCLES or DIV_CYCLES cycles.
module mdu_sequencer
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic issue_div,
    output logic idle,
    output logic start,
    output logic is_div,
    output logic busy
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;

    assign idle = (state == IDLE);

    // FSM with counter; start/is_div/busy are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            start  <= 1'b0;
            is_div <= 1'b0;
            busy   <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state  <= RUN;
                        cnt    <= issue_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                        start  <= 1'b1;
                        is_div <= issue_div;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    // The last busy cycle is the one where the counter reads zero
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller: load-use and MDU-busy stalls,
// taken-branch squash, and MDU issue sequencing.
module hazard_stall_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic                 iClk,
    input  logic                 iReset,
    hazard_stall_ctrl_if.slave   bus
);
    logic load_use;
    logic mdu_haz;
    logic mdu_req;
    logic issue;
    logic seq_idle;
    logic mdu_start;
    logic mdu_is_div;
    logic mdu_busy;

    // Hazard detection and MDU issue qualification
    always_comb begin
        load_use = bus.iExMemRead && (bus.iExRegRt != REG_ZERO) &&
                   ((bus.iExRegRt == bus.iIdRegRs) ||
                    (bus.iIdUsesRt && (bus.iExRegRt == bus.iIdRegRt)));
        mdu_haz  = mdu_busy && (bus.iIdMduOp != MDU_NONE);
        mdu_req  = (bus.iIdMduOp == MDU_MUL) || (bus.iIdMduOp == MDU_DIV);
        // mfhi/mflo never issue; a branch squashes the ID instruction first
        issue    = seq_idle && mdu_req && !bus.iExBranchTaken && !load_use;
    end

    mdu_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu_seq (
        .clk       (iClk),
        .rst       (iReset),
        .issue     (issue),
        .issue_div (bus.iIdMduOp == MDU_DIV),
        .idle      (seq_idle),
        .start     (mdu_start),
        .is_div    (mdu_is_div),
        .busy      (mdu_busy)
    );

    assign bus.oMduStart = mdu_start;
    assign bus.oMduIsDiv = mdu_is_div;
    assign bus.oMduBusy  = mdu_busy;

    // Pipeline-register control priority: reset, branch squash, stall, run
    always_comb begin
        bus.oPcWrite    = 1'b1;
        bus.oIfIdWrite  = 1'b1;
        bus.oIfIdFlush  = 1'b0;
        bus.oIdExBubble = 1'b0;
        if (iReset) begin
            bus.oPcWrite    = 1'b0;
            bus.oIfIdWrite  = 1'b0;
            bus.oIdExBubble = 1'b1;
        end else if (bus.iExBranchTaken) begin
            bus.oIfIdFlush  = 1'b1;
            bus.oIdExBubble = 1'b1;
        end else if (load_use || mdu_haz) begin
            bus.oPcWrite    = 1'b0;
            bus.oIfIdWrite  = 1'b0;
            bus.oIdExBubble = 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MUL_CYCLES=4, DIV_CYCLES=32).
module tb_hazard_stall_ctrl;
    logic iClk;
    logic iReset;
    int   checks;
    int   errors;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32)
    ) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pc write, if/id write, flush, bubble in one go
    task automatic chk_ctl(input string tag, input logic pc, input logic ifw,
                           input logic fl, input logic bub);
        chk({tag, ".pc"},    {31'd0, bus.oPcWrite},    {31'd0, pc});
        chk({tag, ".ifw"},   {31'd0, bus.oIfIdWrite},  {31'd0, ifw});
        chk({tag, ".flush"}, {31'd0, bus.oIfIdFlush},  {31'd0, fl});
        chk({tag, ".bub"},   {31'd0, bus.oIdExBubble}, {31'd0, bub});
    endtask

    task automatic chk_mdu(input string tag, input logic st, input logic dv, input logic bz);
        chk({tag, ".start"}, {31'd0, bus.oMduStart}, {31'd0, st});
        chk({tag, ".isdiv"}, {31'd0, bus.oMduIsDiv}, {31'd0, dv});
        chk({tag, ".busy"},  {31'd0, bus.oMduBusy},  {31'd0, bz});
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iIdRegRs       = 5'd0;
        bus.iIdRegRt       = 5'd0;
        bus.iIdUsesRt      = 1'b0;
        bus.iIdMduOp       = 2'b00;
        bus.iExMemRead     = 1'b0;
        bus.iExRegRt       = 5'd0;
        bus.iExBranchTaken = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        iReset = 1'b1;
        #2;
        // Reset state
        chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b1);
        chk_mdu("rst", 1'b0, 1'b0, 1'b0);
        step();
        step();
        iReset = 1'b0;
        #1;
        chk_ctl("run", 1'b1, 1'b1, 1'b0, 1'b0);

        // 1. load-use on Rs
        bus.iExMemRead = 1'b1; bus.iExRegRt = 5'd5; bus.iIdRegRs = 5'd5;
        #1;
        chk_ctl("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1);
        bus.iExRegRt = 5'd0; bus.iIdRegRs = 5'd0;
        #1;
        chk_ctl("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0);

        // 2. Rt-only match depends on iIdUsesRt
        bus.iExRegRt = 5'd7; bus.iIdRegRt = 5'd7; bus.iIdRegRs = 5'd3; bus.iIdUsesRt = 1'b0;
        #1;
        chk_ctl("rt_nouse", 1'b1, 1'b1, 1'b0, 1'b0);
        bus.iIdUsesRt = 1'b1;
        #1;
        chk_ctl("rt_use", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_mdu("rt_use_nostart", 1'b0, 1'b0, 1'b0);
        idle_inputs();

        // 3. mul issue, then div held in ID until the MDU frees up
        bus.iIdMduOp = 2'b01;
        #1;
        chk_ctl("mul_id", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        bus.iIdMduOp = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk_mdu($sformatf("mul_busy%0d", k), (k == 1), 1'b0, 1'b1);
            chk_ctl($sformatf("div_stall%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end
        #1;
        chk_mdu("mul_done", 1'b0, 1'b0, 1'b0);
        chk_ctl("div_go", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        bus.iIdMduOp = 2'b00;
        chk_mdu("div_start", 1'b1, 1'b1, 1'b1);

        // 5. reset pulse between edges in div busy cycle 10
        for (int k = 1; k <= 9; k++) step();
        chk_mdu("div_busy10", 1'b0, 1'b1, 1'b1);
        #1;
        iReset = 1'b1;
        #1;
        chk_mdu("div_rst", 1'b0, 1'b0, 1'b0);
        chk_ctl("div_rst", 1'b0, 1'b0, 1'b0, 1'b1);
        iReset = 1'b0;
        bus.iIdMduOp = 2'b01;
        #1;
        chk_ctl("mul2_id", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_mdu("mul2_start", 1'b1, 1'b0, 1'b1);

        // 6. mfhi stalls for the rest of the mul busy window
        bus.iIdMduOp = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk_mdu($sformatf("mfhi_busy%0d", k), (k == 1), 1'b0, 1'b1);
            chk_ctl($sformatf("mfhi_stall%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end
        #1;
        chk_ctl("mfhi_go", 1'b1, 1'b1, 1'b0, 1'b0);
        chk_mdu("mfhi_go", 1'b0, 1'b0, 1'b0);
        step();
        chk_mdu("mfhi_nostart", 1'b0, 1'b0, 1'b0);
        chk_ctl("mfhi_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // 4. taken branch beats load-use and mul issue
        bus.iIdMduOp = 2'b01; bus.iExMemRead = 1'b1; bus.iExRegRt = 5'd9;
        bus.iIdRegRs = 5'd9; bus.iExBranchTaken = 1'b1;
        #1;
        chk_ctl("br", 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        idle_inputs();
        chk_mdu("br_nostart", 1'b0, 1'b0, 1'b0);

        // taken branch during a run does not abort the MDU
        bus.iIdMduOp = 2'b01;
        step();
        bus.iIdMduOp = 2'b00; bus.iExBranchTaken = 1'b1;
        chk_mdu("br_run_start", 1'b1, 1'b0, 1'b1);
        step();
        chk_mdu("br_run_busy", 1'b0, 1'b0, 1'b1);
        bus.iExBranchTaken = 1'b0;
        step();
        step();
        chk_mdu("br_run_busy4", 1'b0, 1'b0, 1'b1);
        step();
        chk_mdu("br_run_done", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
